// File: rtl/elmnt_wise_mult_seq_pkg.sv
// Shared Q-format defaults, FSM state encoding and beat-count helpers
// for the time-multiplexed element-wise multiplier.
package elmnt_wise_mult_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nbeats(input int n_reg, input int p_lanes);
    return (n_reg + p_lanes - 1) / p_lanes;
  endfunction

  // A single-beat schedule still needs a one-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/elmnt_wise_mult_seq_mult_q_lane.sv
// One combinational Q-format multiply lane: full product, arithmetic shift,
// then wrap or clamp (clamp when ELMNT_MULT_SAT_EN is defined).
module mult_q_lane
  import elmnt_wise_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] w_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic        [WIDTH:0]     hi;

  assign a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_ext   = {{WIDTH{w[WIDTH-1]}}, w};
  assign prod    = a_ext * w_ext;
  assign shifted = prod >>> FBITS;

  // In range only when every bit from the result sign upward agrees.
  assign hi  = shifted[2*WIDTH-1:WIDTH-1];
  assign ovf = ~((&hi) | ~(|hi));

`ifdef ELMNT_MULT_SAT_EN
  assign y = ovf ? (shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}})
                 : shifted[WIDTH-1:0];
`else
  assign y = shifted[WIDTH-1:0];
`endif

endmodule

// File: rtl/elmnt_wise_mult_seq.sv
// Handshaked element-wise Q multiplier: P_LANES lanes swept over N_REG elements
// with a sticky overflow flag. ELMNT_MULT_SAT_EN selects clamping over wrapping.
module elmnt_wise_mult_seq
  import elmnt_wise_mult_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FBITS   = DEF_FBITS,
  parameter int N_REG   = 31,
  parameter int P_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_REG*WIDTH-1:0] all_a,
  input  logic [N_REG*WIDTH-1:0] all_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_REG*WIDTH-1:0] all_mult,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int NBEATS = nbeats(N_REG, P_LANES);
  localparam int CW     = cnt_width(NBEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  state_t                   state;
  logic [CW-1:0]            beat;
  logic [CW-1:0]            stg_beat;
  logic                     issuing;
  logic                     stg_vld;
  logic [N_REG*WIDTH-1:0]   buf_a;
  logic [N_REG*WIDTH-1:0]   buf_w;
  logic [N_REG*WIDTH-1:0]   mult_nxt;
  logic                     ovf_nxt;
  logic [P_LANES*WIDTH-1:0] lane_a;
  logic [P_LANES*WIDTH-1:0] lane_w;
  logic [P_LANES*WIDTH-1:0] lane_y;
  logic [P_LANES*WIDTH-1:0] stg_y;
  logic [P_LANES-1:0]       lane_ovf;
  logic [P_LANES-1:0]       stg_ovf;

  // Lanes past the last element in a partial beat are fed zero.
  always_comb begin
    lane_a = '0;
    lane_w = '0;
    for (int l = 0; l < P_LANES; l++) begin
      if (int'(beat) * P_LANES + l < N_REG) begin
        lane_a[l*WIDTH +: WIDTH] = buf_a[(int'(beat) * P_LANES + l) * WIDTH +: WIDTH];
        lane_w[l*WIDTH +: WIDTH] = buf_w[(int'(beat) * P_LANES + l) * WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < P_LANES; g++) begin : g_lane
    mult_q_lane #(
      .WIDTH (WIDTH),
      .FBITS (FBITS)
    ) u_lane (
      .a   (lane_a[g*WIDTH +: WIDTH]),
      .w   (lane_w[g*WIDTH +: WIDTH]),
      .y   (lane_y[g*WIDTH +: WIDTH]),
      .ovf (lane_ovf[g])
    );
  end

  // Registered lane results land in the result buffer one cycle after issue.
  always_comb begin
    mult_nxt = all_mult;
    ovf_nxt  = out_ovf;
    for (int l = 0; l < P_LANES; l++) begin
      if (stg_vld && (int'(stg_beat) * P_LANES + l < N_REG)) begin
        mult_nxt[(int'(stg_beat) * P_LANES + l) * WIDTH +: WIDTH] = stg_y[l*WIDTH +: WIDTH];
        ovf_nxt = ovf_nxt | stg_ovf[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      stg_beat  <= '0;
      issuing   <= 1'b0;
      stg_vld   <= 1'b0;
      stg_y     <= '0;
      stg_ovf   <= '0;
      buf_a     <= '0;
      buf_w     <= '0;
      all_mult  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            buf_a    <= all_a;
            buf_w    <= all_w;
            out_ovf  <= 1'b0;
            beat     <= '0;
            issuing  <= 1'b1;
            stg_vld  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          stg_vld  <= issuing;
          stg_beat <= beat;
          stg_y    <= lane_y;
          stg_ovf  <= lane_ovf;
          all_mult <= mult_nxt;
          out_ovf  <= ovf_nxt;
          if (issuing) begin
            if (beat == LAST_BEAT) begin
              issuing <= 1'b0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
          if (stg_vld && (stg_beat == LAST_BEAT)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elmnt_wise_mult_seq.sv
// Self-checking bench for elmnt_wise_mult_seq: directed Q-format cases plus
// random vectors against an integer-arithmetic reference, for 4, 31 and 1 lanes.
module tb_elmnt_wise_mult_seq;

  localparam int W = 32;
  localparam int F = 24;
  localparam int N = 31;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [N*W-1:0] all_a;
  logic [N*W-1:0] all_w;

  logic           in_ready4, out_valid4, out_ovf4, busy4;
  logic [N*W-1:0] all_mult4;
  logic           in_ready31, out_valid31, out_ovf31, busy31;
  logic [N*W-1:0] all_mult31;
  logic           in_ready1, out_valid1, out_ovf1, busy1;
  logic [N*W-1:0] all_mult1;

  int asserts = 0;
  int fails   = 0;

  elmnt_wise_mult_seq #(.WIDTH(W), .FBITS(F), .N_REG(N), .P_LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .all_a(all_a), .all_w(all_w), .out_valid(out_valid4), .out_ready(out_ready),
    .all_mult(all_mult4), .out_ovf(out_ovf4), .busy(busy4)
  );

  elmnt_wise_mult_seq #(.WIDTH(W), .FBITS(F), .N_REG(N), .P_LANES(31)) u_dut_p31 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready31),
    .all_a(all_a), .all_w(all_w), .out_valid(out_valid31), .out_ready(out_ready),
    .all_mult(all_mult31), .out_ovf(out_ovf31), .busy(busy31)
  );

  elmnt_wise_mult_seq #(.WIDTH(W), .FBITS(F), .N_REG(N), .P_LANES(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .all_a(all_a), .all_w(all_w), .out_valid(out_valid1), .out_ready(out_ready),
    .all_mult(all_mult1), .out_ovf(out_ovf1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: exact signed product, floor shift, then wrap or clamp.
  task automatic model_vec(input logic [N*W-1:0] a, input logic [N*W-1:0] w,
                           output logic [N*W-1:0] y, output logic ovf);
    longint p;
    longint s;
    logic   e_ovf;
    y   = '0;
    ovf = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = longint'($signed(a[k*W +: W])) * longint'($signed(w[k*W +: W]));
      s = p >>> F;
      e_ovf = (s > QMAX) || (s < QMIN);
      ovf = ovf | e_ovf;
`ifdef ELMNT_MULT_SAT_EN
      if (e_ovf) y[k*W +: W] = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else       y[k*W +: W] = s[31:0];
`else
      y[k*W +: W] = s[31:0];
`endif
    end
  endtask

  function automatic logic [N*W-1:0] rand_small();
    logic [N*W-1:0] v;
    logic [31:0]    r;
    for (int k = 0; k < N; k++) begin
      r = $urandom();
      v[k*W +: W] = {{6{r[25]}}, r[25:0]};
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_full();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = $urandom();
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [N*W-1:0] obs,
                             input logic [N*W-1:0] exp);
    int idx;
    asserts++;
    assert (obs === exp) else begin
      fails++;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) if (obs[k*W +: W] !== exp[k*W +: W]) idx = k;
      $error("[TB] FAIL %s: element %0d observed %h required %h",
             tag, idx, obs[idx*W +: W], exp[idx*W +: W]);
    end
  endtask

  // Presents one vector pair and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [N*W-1:0] a, input logic [N*W-1:0] w);
    @(negedge clk);
    checkOutput("in_ready_before_accept", N*W'(in_ready4), N*W'(1));
    all_a    = a;
    all_w    = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (out_valid4) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drainOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] va, vw, ev, vb_a, vb_w, eb;
    logic           eo, ebo;
    int             lat, l4, l31, l1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    all_a = '0; all_w = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  N*W'(in_ready4),  N*W'(1));
    checkOutput("rst_out_valid", N*W'(out_valid4), N*W'(0));
    checkOutput("rst_busy",      N*W'(busy4),      N*W'(0));
    checkOutput("rst_out_ovf",   N*W'(out_ovf4),   N*W'(0));
    checkOutput("rst_all_mult",  all_mult4,        '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed Q8.24 values, truncation and latency");
    va = rand_small(); vw = rand_small();
    va[0*W +: W]  = 32'h0180_0000; vw[0*W +: W]  = 32'h0200_0000;
    va[30*W +: W] = 32'hFF00_0000; vw[30*W +: W] = 32'h0080_0000;
    va[1*W +: W]  = 32'hFFFF_FFFF; vw[1*W +: W]  = 32'h0080_0000;
    va[2*W +: W]  = 32'h0000_0001; vw[2*W +: W]  = 32'h0080_0000;
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    checkOutput("run_busy",     N*W'(busy4),     N*W'(1));
    checkOutput("run_in_ready", N*W'(in_ready4), N*W'(0));
    all_a = rand_full(); all_w = rand_full(); in_valid = 1'b1;
    waitResult(lat);
    in_valid = 1'b0;
    checkOutput("latency_p4",  N*W'(lat), N*W'(9));
    checkOutput("elt0_1p5x2",  N*W'(all_mult4[0*W +: W]),  N*W'(32'h0300_0000));
    checkOutput("elt30_m1xh",  N*W'(all_mult4[30*W +: W]), N*W'(32'hFF80_0000));
    checkOutput("elt1_trunc_neg", N*W'(all_mult4[1*W +: W]), N*W'(32'hFFFF_FFFF));
    checkOutput("elt2_trunc_pos", N*W'(all_mult4[2*W +: W]), N*W'(32'h0000_0000));
    checkOutput("vec_directed", all_mult4, ev);
    checkOutput("ovf_directed", N*W'(out_ovf4), N*W'(0));
    drainOutput();

    $display("[TB] overflow element");
    va = rand_small(); vw = rand_small();
    va[5*W +: W] = 32'h6400_0000; vw[5*W +: W] = 32'h0200_0000;
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    waitResult(lat);
`ifdef ELMNT_MULT_SAT_EN
    checkOutput("elt5_overflow", N*W'(all_mult4[5*W +: W]), N*W'(32'h7FFF_FFFF));
`else
    checkOutput("elt5_overflow", N*W'(all_mult4[5*W +: W]), N*W'(32'hC800_0000));
`endif
    checkOutput("ovf_set",      N*W'(out_ovf4), N*W'(1));
    checkOutput("vec_overflow", all_mult4, ev);
    drainOutput();

    $display("[TB] in-range vector clears overflow");
    va = rand_small(); vw = rand_small();
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    waitResult(lat);
    checkOutput("ovf_cleared",  N*W'(out_ovf4), N*W'(eo));
    checkOutput("vec_in_range", all_mult4, ev);
    drainOutput();

    $display("[TB] backpressure in DONE");
    va = rand_full(); vw = rand_full();
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    waitResult(lat);
    vb_a = rand_small(); vb_w = rand_small();
    model_vec(vb_a, vb_w, eb, ebo);
    all_a = vb_a; all_w = vb_w; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_all_mult", all_mult4, ev);
      checkOutput("bp_out_ovf",  N*W'(out_ovf4),   N*W'(eo));
      checkOutput("bp_valid",    N*W'(out_valid4), N*W'(1));
      checkOutput("bp_in_ready", N*W'(in_ready4),  N*W'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("hs_busy",     N*W'(busy4),      N*W'(0));
    checkOutput("hs_in_ready", N*W'(in_ready4),  N*W'(1));
    checkOutput("hs_valid",    N*W'(out_valid4), N*W'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("next_accept_busy", N*W'(busy4), N*W'(1));
    waitResult(lat);
    checkOutput("latency_after_bp", N*W'(lat), N*W'(9));
    checkOutput("vec_after_bp", all_mult4, eb);
    checkOutput("ovf_after_bp", N*W'(out_ovf4), N*W'(ebo));
    drainOutput();

    $display("[TB] reset during RUN");
    va = rand_full(); vw = rand_full();
    applyStimulus(va, vw);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_in_ready",  N*W'(in_ready4),  N*W'(1));
    checkOutput("mid_rst_out_valid", N*W'(out_valid4), N*W'(0));
    checkOutput("mid_rst_busy",      N*W'(busy4),      N*W'(0));
    checkOutput("mid_rst_out_ovf",   N*W'(out_ovf4),   N*W'(0));
    checkOutput("mid_rst_all_mult",  all_mult4,        '0);
    @(negedge clk);
    rst_n = 1'b1;
    va = rand_full(); vw = rand_full();
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    waitResult(lat);
    checkOutput("post_rst_latency", N*W'(lat), N*W'(9));
    checkOutput("post_rst_vec", all_mult4, ev);
    checkOutput("post_rst_ovf", N*W'(out_ovf4), N*W'(eo));
    drainOutput();

    $display("[TB] lane-count variants 31, 4 and 1");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    va = rand_full(); vw = rand_full();
    va[3*W +: W] = 32'h0180_0000; vw[3*W +: W] = 32'hFE00_0000;
    model_vec(va, vw, ev, eo);
    applyStimulus(va, vw);
    l4 = 0; l31 = 0; l1 = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (out_valid31 && l31 == 0) l31 = e;
      if (out_valid4  && l4  == 0) l4  = e;
      if (out_valid1  && l1  == 0) l1  = e;
    end
    checkOutput("latency_p31", N*W'(l31), N*W'(2));
    checkOutput("latency_p4b", N*W'(l4),  N*W'(9));
    checkOutput("latency_p1",  N*W'(l1),  N*W'(32));
    checkOutput("vec_p31", all_mult31, ev);
    checkOutput("vec_p4",  all_mult4,  ev);
    checkOutput("vec_p1",  all_mult1,  ev);
    checkOutput("ovf_p31", N*W'(out_ovf31), N*W'(eo));
    checkOutput("ovf_p1",  N*W'(out_ovf1),  N*W'(eo));
    checkOutput("elt3_neg_p1", N*W'(all_mult1[3*W +: W]), N*W'(32'hFD00_0000));
    drainOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
